// File: rtl/range_list_producer_pkg.sv
// Shared definitions for list producers: handshake FSM state encoding,
// handshake signal ordering and default data width.
package range_list_producer_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned STATE_W       = 3;

  // Legacy-compatible state encoding shared by all list responders
  localparam logic [STATE_W-1:0] IDLE     = 3'd0;
  localparam logic [STATE_W-1:0] WAIT_REQ = 3'd1;
  localparam logic [STATE_W-1:0] COMPUTE  = 3'd2;
  localparam logic [STATE_W-1:0] ACK      = 3'd3;
  localparam logic [STATE_W-1:0] WAIT_REL = 3'd4;

  // Handshake control bits in their canonical order (MSB first)
  typedef struct packed {
    logic req;
    logic ack;
    logic value_valid;
  } list_hs_t;

endpackage

// File: rtl/range_list_producer_if.sv
// List handshake bundle: consumer (master) requests, producer (slave) answers.
interface range_list_producer_if
  import range_list_producer_pkg::*;
  #(parameter int unsigned WIDTH = DEFAULT_WIDTH) ();

  logic             ready;
  logic             done;
  logic [WIDTH-1:0] arg_from;
  logic [WIDTH-1:0] arg_to;
  logic [WIDTH-1:0] arg_step;
  logic             req;
  logic             ack;
  logic [WIDTH-1:0] value;
  logic             value_valid;

  modport master (
    output ready, arg_from, arg_to, arg_step, req,
    input  done, ack, value, value_valid
  );

  modport slave (
    input  ready, arg_from, arg_to, arg_step, req,
    output done, ack, value, value_valid
  );

endinterface

// File: rtl/range_list_producer_responder.sv
// Generic 4-phase req/ack responder for list producers; exposes start,
// element_request and element_taken strobes so the data path stays outside.
module list_handshake_responder
  import range_list_producer_pkg::*;
  #(parameter int unsigned LATENCY = 2) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic ready,
  input  logic req,
  output logic done,
  output logic ack,
  output logic start_c,
  output logic element_request_c,
  output logic element_taken_c
);

  localparam int unsigned       CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0]  CNT_LOAD = (LATENCY == 0) ? '0 : CNT_W'(LATENCY - 1);

  logic [STATE_W-1:0] state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ack_d, done_d;

  // State, counter and registered handshake outputs
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ack     <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack     <= ack_d;
      done    <= done_d;
    end
  end

  // Next state and output decode; ready low overrides everything
  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    ack_d             = ack;
    done_d            = done;
    start_c           = 1'b0;
    element_request_c = 1'b0;
    element_taken_c   = 1'b0;

    if (!ready) begin
      state_d = IDLE;
      ack_d   = 1'b0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          start_c = 1'b1;
          done_d  = 1'b1;
          state_d = WAIT_REQ;
        end
        WAIT_REQ: begin
          if (req) begin
            if (LATENCY == 0) begin
              state_d           = ACK;
              ack_d             = 1'b1;
              element_request_c = 1'b1;
            end else begin
              state_d = COMPUTE;
              cnt_d   = CNT_LOAD;
            end
          end
        end
        // Runs to completion even if req drops meanwhile
        COMPUTE: begin
          if (cnt_q == '0) begin
            state_d           = ACK;
            ack_d             = 1'b1;
            element_request_c = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ACK: begin
          if (!req) begin
            state_d         = WAIT_REL;
            ack_d           = 1'b0;
            element_taken_c = 1'b1;
          end
        end
        WAIT_REL: begin
          state_d = WAIT_REQ;
        end
        default: begin
          state_d = IDLE;
          ack_d   = 1'b0;
          done_d  = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/range_list_producer.sv
// List producer streaming from, from+step, ... up to to (inclusive), then
// answering every further request with end-of-list.
module range_list_producer
  import range_list_producer_pkg::*;
  #(parameter int unsigned WIDTH   = DEFAULT_WIDTH,
    parameter int unsigned LATENCY = 2) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  range_list_producer_if.slave bus
);

  logic             done, ack;
  logic             start_c, element_request_c, element_taken_c;
  logic [WIDTH-1:0] cur_q, cur_d, last_q, last_d, step_q, step_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic             ended_q, ended_d, valid_q, valid_d;
  logic [WIDTH:0]   sum_c;

  list_handshake_responder #(.LATENCY(LATENCY)) u_responder (
    .CLOCK_50          (CLOCK_50),
    .reset             (reset),
    .ready             (bus.ready),
    .req               (bus.req),
    .done              (done),
    .ack               (ack),
    .start_c           (start_c),
    .element_request_c (element_request_c),
    .element_taken_c   (element_taken_c)
  );

  // Carry bit detects overflow past the top of the WIDTH range
  assign sum_c = {1'b0, cur_q} + {1'b0, step_q};

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      cur_q   <= '0;
      last_q  <= '0;
      step_q  <= '0;
      ended_q <= 1'b0;
      value_q <= '0;
      valid_q <= 1'b0;
    end else begin
      cur_q   <= cur_d;
      last_q  <= last_d;
      step_q  <= step_d;
      ended_q <= ended_d;
      value_q <= value_d;
      valid_q <= valid_d;
    end
  end

  // Argument latch, element presentation and advance
  always_comb begin
    cur_d   = cur_q;
    last_d  = last_q;
    step_d  = step_q;
    ended_d = ended_q;
    value_d = value_q;
    valid_d = valid_q;

    if (!bus.ready) begin
      value_d = '0;
      valid_d = 1'b0;
    end else if (start_c) begin
      cur_d   = bus.arg_from;
      last_d  = bus.arg_to;
      step_d  = (bus.arg_step == '0) ? WIDTH'(1) : bus.arg_step;
      ended_d = (bus.arg_from > bus.arg_to);
      value_d = '0;
      valid_d = 1'b0;
    end else if (element_request_c) begin
      value_d = ended_q ? '0 : cur_q;
      valid_d = ~ended_q;
    end else if (element_taken_c) begin
      value_d = '0;
      valid_d = 1'b0;
      if (!ended_q) begin
        if (sum_c[WIDTH] || (sum_c[WIDTH-1:0] > last_q)) begin
          ended_d = 1'b1;
        end else begin
          cur_d = sum_c[WIDTH-1:0];
        end
      end
    end
  end

  assign bus.done        = done;
  assign bus.ack         = ack;
  assign bus.value       = value_q;
  assign bus.value_valid = valid_q;

endmodule

// File: tb/tb_range_list_producer.sv
// Directed bench for range_list_producer: one DUT with LATENCY=2, one with LATENCY=0.
module tb_range_list_producer;

  logic CLOCK_50;
  logic reset;
  int   n_cmp;
  int   n_err;

  range_list_producer_if #(.WIDTH(8)) bus_a ();
  range_list_producer_if #(.WIDTH(8)) bus_b ();

  range_list_producer #(.WIDTH(8), .LATENCY(2)) dut_a (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .bus      (bus_a)
  );

  range_list_producer #(.WIDTH(8), .LATENCY(0)) dut_b (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .bus      (bus_b)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_ack(input int sel);
    return (sel == 0) ? bus_a.ack : bus_b.ack;
  endfunction

  function automatic logic get_vv(input int sel);
    return (sel == 0) ? bus_a.value_valid : bus_b.value_valid;
  endfunction

  function automatic logic [7:0] get_val(input int sel);
    return (sel == 0) ? bus_a.value : bus_b.value;
  endfunction

  task automatic set_req(input int sel, input logic v);
    if (sel == 0) bus_a.req = v;
    else          bus_b.req = v;
  endtask

  task automatic start_a(input logic [7:0] f, input logic [7:0] t, input logic [7:0] s);
    bus_a.ready = 1'b0;
    tick();
    bus_a.arg_from = f;
    bus_a.arg_to   = t;
    bus_a.arg_step = s;
    bus_a.ready    = 1'b1;
    tick();
  endtask

  // One full 4-phase handshake with latency, element and release checks
  task automatic hs(input int sel, input string tag, input int exp_lat,
                    input logic exp_vv, input logic [7:0] exp_val);
    int n;
    n = 0;
    set_req(sel, 1'b1);
    while (!get_ack(sel) && n < 20) begin
      tick();
      n++;
    end
    chk({tag, " latency"}, 32'(n), 32'(exp_lat));
    chk({tag, " value_valid"}, 32'(get_vv(sel)), 32'(exp_vv));
    chk({tag, " value"}, 32'(get_val(sel)), 32'(exp_val));
    set_req(sel, 1'b0);
    tick();
    chk({tag, " ack release"}, 32'(get_ack(sel)), 32'd0);
    chk({tag, " vv release"}, 32'(get_vv(sel)), 32'd0);
    tick();
  endtask

  initial begin
    int n;
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    bus_a.ready = 1'b0; bus_a.req = 1'b0;
    bus_a.arg_from = '0; bus_a.arg_to = '0; bus_a.arg_step = '0;
    bus_b.ready = 1'b0; bus_b.req = 1'b0;
    bus_b.arg_from = '0; bus_b.arg_to = '0; bus_b.arg_step = '0;
    tick();
    tick();
    chk("reset done", 32'(bus_a.done), 32'd0);
    chk("reset ack", 32'(bus_a.ack), 32'd0);
    chk("reset value", 32'(bus_a.value), 32'd0);
    chk("reset vv", 32'(bus_a.value_valid), 32'd0);
    reset = 1'b0;

    // 1..4 step 1, LATENCY=2
    start_a(8'd1, 8'd4, 8'd1);
    chk("t1 done", 32'(bus_a.done), 32'd1);
    hs(0, "t1 e1", 3, 1'b1, 8'd1);
    hs(0, "t1 e2", 3, 1'b1, 8'd2);
    hs(0, "t1 e3", 3, 1'b1, 8'd3);
    hs(0, "t1 e4", 3, 1'b1, 8'd4);
    hs(0, "t1 end", 3, 1'b0, 8'd0);

    // 250..255 step 4: no wrap past 255
    start_a(8'd250, 8'd255, 8'd4);
    hs(0, "t2 e1", 3, 1'b1, 8'd250);
    hs(0, "t2 e2", 3, 1'b1, 8'd254);
    hs(0, "t2 end", 3, 1'b0, 8'd0);
    hs(0, "t2 end2", 3, 1'b0, 8'd0);

    // from > to: empty list
    start_a(8'd5, 8'd3, 8'd1);
    hs(0, "t3 end", 3, 1'b0, 8'd0);
    hs(0, "t3 end2", 3, 1'b0, 8'd0);

    // ready dropped while presenting 7, then relatch 10..11
    start_a(8'd7, 8'd9, 8'd1);
    bus_a.req = 1'b1;
    n = 0;
    while (!bus_a.ack && n < 20) begin tick(); n++; end
    chk("t5 ack", 32'(bus_a.ack), 32'd1);
    chk("t5 value", 32'(bus_a.value), 32'd7);
    bus_a.ready = 1'b0;
    tick();
    chk("t5 drop ack", 32'(bus_a.ack), 32'd0);
    chk("t5 drop done", 32'(bus_a.done), 32'd0);
    chk("t5 drop vv", 32'(bus_a.value_valid), 32'd0);
    bus_a.req = 1'b0;
    bus_a.arg_from = 8'd10;
    bus_a.arg_to   = 8'd11;
    bus_a.ready    = 1'b1;
    tick();
    hs(0, "t5 e1", 3, 1'b1, 8'd10);

    // async reset in COMPUTE, then 3..3
    bus_a.req = 1'b1;
    tick();
    chk("t6 pre done", 32'(bus_a.done), 32'd1);
    reset = 1'b1;
    #1;
    chk("t6 async done", 32'(bus_a.done), 32'd0);
    chk("t6 async ack", 32'(bus_a.ack), 32'd0);
    chk("t6 async value", 32'(bus_a.value), 32'd0);
    chk("t6 async vv", 32'(bus_a.value_valid), 32'd0);
    bus_a.req = 1'b0;
    bus_a.arg_from = 8'd3;
    bus_a.arg_to   = 8'd3;
    bus_a.arg_step = 8'd1;
    tick();
    reset = 1'b0;
    tick();
    chk("t6 done", 32'(bus_a.done), 32'd1);
    hs(0, "t6 e1", 3, 1'b1, 8'd3);
    hs(0, "t6 end", 3, 1'b0, 8'd0);

    // req dropped during COMPUTE: element still delivered and consumed
    start_a(8'd20, 8'd30, 8'd5);
    bus_a.req = 1'b1;
    tick();
    bus_a.req = 1'b0;
    tick();
    tick();
    chk("t7 ack", 32'(bus_a.ack), 32'd1);
    chk("t7 value", 32'(bus_a.value), 32'd20);
    tick();
    chk("t7 ack fall", 32'(bus_a.ack), 32'd0);
    tick();
    hs(0, "t7 e2", 3, 1'b1, 8'd25);

    // LATENCY=0, step 0 treated as 1
    bus_b.arg_from = 8'd0;
    bus_b.arg_to   = 8'd2;
    bus_b.arg_step = 8'd0;
    bus_b.ready    = 1'b1;
    tick();
    chk("t4 done", 32'(bus_b.done), 32'd1);
    hs(1, "t4 e1", 1, 1'b1, 8'd0);
    hs(1, "t4 e2", 1, 1'b1, 8'd1);
    hs(1, "t4 e3", 1, 1'b1, 8'd2);
    hs(1, "t4 end", 1, 1'b0, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
